rfile_np: RTL and testbench
===========================

RFILE_NP -- requirements
Module: rfile_np

Interface
REQ-001 Parameter DW, 32, data width in bits.
REQ-002 Parameter AW, 5, address width; DEPTH = 2**AW entries.
REQ-003 Parameter NR, 2, number of read ports (1..4).
REQ-004 Parameter ZERO_R0, 1, entry 0 reads as zero and ignores writes when 1.
REQ-005 Clk  in  1  single clock; all state updates on posedge.
REQ-006 Rst  in  1  reset, synchronous and active-high.
REQ-007 Run  in  1  global enable for writes; 0 drops writes.
REQ-008 Clr  in  1  one-cycle pulse; restarts the clear sequence.
REQ-009 Stall  in  1  holds all read outputs when 1.
REQ-010 Ra  in  NR*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-011 RegWr  in  1  write request.
REQ-012 Rw  in  AW  write address.
REQ-013 busW  in  DW  write data.
REQ-014 busR  out  NR*DW  registered read data; port k occupies bits [k*DW +: DW].
REQ-015 Ready  out  1  high when the clear sequence is done and the file is usable.

Function
REQ-016 Two states: S_CLEAR, S_READY; a clear pointer cptr of width AW+1 advances in S_CLEAR.
REQ-017 In S_CLEAR, each cycle writes 0 to entry cptr and increments cptr.
REQ-018 When cptr reaches DEPTH-1 and that entry is cleared, the next state is S_READY; the full clear takes exactly DEPTH cycles.
REQ-019 Clr in any state sets state to S_CLEAR and cptr to 0 on the next edge; Clr during S_CLEAR restarts from 0.
REQ-020 Ready = (state == S_READY), registered.
REQ-021 Write condition is S_READY & Run & RegWr & !Clr & !(ZERO_R0 & Rw==0); on an edge where it holds, busW is stored to Rw.
REQ-022 All writes are dropped in S_CLEAR and in the Clr cycle.
REQ-023 Read latency is 1 cycle: busR port k at edge n+1 reflects Ra port k sampled at edge n.
REQ-024 Write-through bypass: if the write condition holds and Rw == Ra[k], port k captures busW, not the stale entry.
REQ-025 With ZERO_R0=1, Ra[k]==0 captures 0 regardless of bypass.
REQ-026 While state is S_CLEAR, every port captures 0.
REQ-027 Stall=1 holds busR unchanged, while writes and clear still proceed.
REQ-028 Reads on different ports are independent; identical addresses on several ports return identical data.

Reset
REQ-029 Rst=1 at an edge sets busR=0, Ready=0, state=S_CLEAR and cptr=0; Rst takes priority over Clr, Stall and writes.
REQ-030 Rst during S_CLEAR restarts the clear from entry 0; after Rst is released, Ready rises exactly DEPTH cycles later.
REQ-031 Storage contents are defined only by the clear sequence; there is no file preload.

Structure
REQ-032 Package rfile_pkg holds the state enum (S_CLEAR, S_READY) and the default values of DW, AW and NR.
REQ-033 One sub-module, rfile_rdport (address decode, bypass, zero and stall mux, output register), is instantiated NR times in a generate loop.
REQ-034 Storage is a single DEPTH x DW array with one write port, which the clear sequence and the user write share through a mux.

Verification
REQ-035 Rst for 1 cycle, then idle -> Ready=0 for 32 cycles, then Ready=1; all 32 entries read 0.
REQ-036 Ready, write Rw=5, busW=0xDEADBEEF with Ra0=5 in the same cycle -> busR port 0 = 0xDEADBEEF next cycle; Ra1=5 the cycle after also returns 0xDEADBEEF.
REQ-037 Write Rw=0, busW=0x1234 with ZERO_R0=1 -> reading address 0 returns 0; with ZERO_R0=0, reading address 0 returns 0x1234.
REQ-038 Write 0xA to reg 3, then Stall=1 with Ra0 changed from 3 to 4 for 3 cycles -> busR port 0 stays 0xA; one cycle after Stall drops it shows reg 4.
REQ-039 Clr with RegWr=1, Rw=7 in the same cycle -> write dropped, Ready low for 32 cycles, reg 7 then reads 0; Run=0 writes are likewise ignored.
REQ-040 Rst asserted at clear cycle 10 -> Ready rises exactly 32 cycles after Rst is released.

Source files
------------

// File: rtl/rfile_pkg.sv
// Shared types and default geometry for the rfile_np register file.
package rfile_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;
  localparam int unsigned NR_DEF = 2;

  typedef enum logic {
    S_CLEAR,
    S_READY
  } rf_state_e;

endpackage

// File: rtl/rfile_rdport.sv
// One registered read port: address decode, write-through bypass, zero/clear
// forcing and stall hold in front of the output register.
module rfile_rdport
  import rfile_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  rf_state_e       state_i,
  input  logic [AW-1:0]   ra_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW-1:0]   mem_i [2**AW],
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] rdata_d, rdata_q;

  // Stall outranks everything except reset, so a stalled port keeps its value
  // even while the file is being cleared.
  always_comb begin
    rdata_d = rdata_q;
    if (!stall_i) begin
      if (state_i == S_CLEAR) begin
        rdata_d = '0;
      end else if (ZERO_R0 && (ra_i == '0)) begin
        rdata_d = '0;
      end else if (we_i && (waddr_i == ra_i)) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem_i[ra_i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rfile_np.sv
// Multi-read-port register file that zeroes itself after reset or Clr before
// accepting writes; one shared write port serves both the clear and user writes.
module rfile_np
  import rfile_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned NR      = NR_DEF,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic             Clr,
  input  logic             Stall,
  input  logic [NR*AW-1:0] Ra,
  input  logic             RegWr,
  input  logic [AW-1:0]    Rw,
  input  logic [DW-1:0]    busW,
  output logic [NR*DW-1:0] busR,
  output logic             Ready
);

  localparam int unsigned DEPTH    = 2**AW;
  localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);

  rf_state_e     state_q, state_d;
  logic [AW:0]   cptr_q, cptr_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          user_we;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  assign user_we = (state_q == S_READY) & Run & RegWr & ~Clr & ~Rst
                 & ~(ZERO_R0 & (Rw == '0));

  always_comb begin
    state_d = state_q;
    cptr_d  = cptr_q;
    if (Clr) begin
      state_d = S_CLEAR;
      cptr_d  = '0;
    end else if (state_q == S_CLEAR) begin
      cptr_d = cptr_q + 1'b1;
      if (cptr_q == LAST_PTR) begin
        state_d = S_READY;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_CLEAR;
      cptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cptr_q  <= cptr_d;
    end
  end

  // The clear sequence owns the write port whenever the file is not ready.
  always_comb begin
    mem_we    = user_we;
    mem_waddr = Rw;
    mem_wdata = busW;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cptr_q[AW-1:0];
      mem_wdata = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    rfile_rdport #(
      .DW     (DW),
      .AW     (AW),
      .ZERO_R0(ZERO_R0)
    ) u_rdport (
      .clk_i  (Clk),
      .rst_i  (Rst),
      .stall_i(Stall),
      .state_i(state_q),
      .ra_i   (Ra[k*AW +: AW]),
      .we_i   (user_we),
      .waddr_i(Rw),
      .wdata_i(busW),
      .mem_i  (mem_q),
      .rdata_o(busR[k*DW +: DW])
    );
  end

  assign Ready = (state_q == S_READY);

endmodule

// File: tb/tb_rfile_np.sv
// Scoreboard bench: two DUTs (ZERO_R0 = 1 and 0) share stimulus; a behavioural
// model predicts each cycle's outputs and a negedge monitor compares them.
module tb_rfile_np;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 2**AW;

  logic             Clk = 1'b0;
  logic             Rst, Run, Clr, Stall, RegWr;
  logic [NR*AW-1:0] Ra;
  logic [AW-1:0]    Rw;
  logic [DW-1:0]    busW;
  logic [NR*DW-1:0] busR_z, busR_n;
  logic             ready_z, ready_n;

  always #5 Clk = ~Clk;

  rfile_np #(.DW(DW), .AW(AW), .NR(NR), .ZERO_R0(1'b1)) u_dut_z (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Clr(Clr), .Stall(Stall), .Ra(Ra),
    .RegWr(RegWr), .Rw(Rw), .busW(busW), .busR(busR_z), .Ready(ready_z)
  );

  rfile_np #(.DW(DW), .AW(AW), .NR(NR), .ZERO_R0(1'b0)) u_dut_n (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Clr(Clr), .Stall(Stall), .Ra(Ra),
    .RegWr(RegWr), .Rw(Rw), .busW(busW), .busR(busR_n), .Ready(ready_n)
  );

  typedef struct packed {
    logic [1:0][NR*DW-1:0] r;
    logic [1:0]            rdy;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_tests = 0;
  int            n_fail  = 0;

  // Model: a clear is observably "file all zero, Ready after DEPTH edges".
  logic [DW-1:0] m_mem [2][DEPTH];
  int            m_left [2];
  logic [DW-1:0] m_r [2][NR];

  task automatic tick();
    exp_t          e;
    bit            zr, rdy_now, wr;
    logic [AW-1:0] ra;
    for (int d = 0; d < 2; d++) begin
      zr      = (d == 0);
      rdy_now = (m_left[d] == 0);
      wr      = rdy_now && Run && RegWr && !Clr && !Rst && !(zr && Rw == '0);
      for (int k = 0; k < NR; k++) begin
        ra = Ra[k*AW +: AW];
        if (Rst)                    m_r[d][k] = '0;
        else if (!Stall) begin
          if (!rdy_now)             m_r[d][k] = '0;
          else if (zr && ra == '0)  m_r[d][k] = '0;
          else if (wr && Rw == ra)  m_r[d][k] = busW;
          else                      m_r[d][k] = m_mem[d][ra];
        end
        e.r[d][k*DW +: DW] = m_r[d][k];
      end
      if (wr) m_mem[d][Rw] = busW;
      if (Rst || Clr) begin
        m_left[d] = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
      end else if (m_left[d] > 0) begin
        m_left[d] = m_left[d] - 1;
      end
      e.rdy[d] = (m_left[d] == 0);
    end
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    Ra = {a1, a0};
  endtask

  task automatic idle();
    Rst = 1'b0; Clr = 1'b0; Stall = 1'b0; Run = 1'b1; RegWr = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_tests += 4;
      if (busR_z !== mon_e.r[0]) begin
        n_fail++;
        $display("FAIL busR_zr1 t=%0t got %h want %h", $time, busR_z, mon_e.r[0]);
      end
      if (busR_n !== mon_e.r[1]) begin
        n_fail++;
        $display("FAIL busR_zr0 t=%0t got %h want %h", $time, busR_n, mon_e.r[1]);
      end
      if (ready_z !== mon_e.rdy[0]) begin
        n_fail++;
        $display("FAIL ready_zr1 t=%0t got %b want %b", $time, ready_z, mon_e.rdy[0]);
      end
      if (ready_n !== mon_e.rdy[1]) begin
        n_fail++;
        $display("FAIL ready_zr0 t=%0t got %b want %b", $time, ready_n, mon_e.rdy[1]);
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_left[d] = DEPTH;
      for (int k = 0; k < NR; k++) m_r[d][k] = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[d][i] = '0;
    end
    idle();
    Ra = '0; Rw = '0; busW = '0;
    #1;

    // Reset, full clear, then sweep every entry
    Rst = 1'b1; tick(); Rst = 1'b0;
    ticks(DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) begin
      set_ra(AW'(i), AW'(DEPTH - 1 - i));
      tick();
    end

    // Same-cycle write bypass, then plain read on port 1
    set_ra(5, 0); Rw = 5; busW = 32'hDEADBEEF; RegWr = 1'b1; tick();
    RegWr = 1'b0; set_ra(0, 5); tick(); tick();

    // Write to entry 0: dropped only when ZERO_R0 = 1
    Rw = 0; busW = 32'h1234; RegWr = 1'b1; tick();
    RegWr = 1'b0; set_ra(0, 0); tick(); tick();

    // Stall hold
    Rw = 3; busW = 32'hA; RegWr = 1'b1; tick();
    RegWr = 1'b0; set_ra(3, 3); tick();
    Stall = 1'b1; set_ra(4, 4); ticks(3);
    Stall = 1'b0; tick(); tick();

    // Clr drops a same-cycle write; Run=0 drops writes too
    Clr = 1'b1; RegWr = 1'b1; Rw = 7; busW = 32'h77; set_ra(7, 7); tick();
    Clr = 1'b0; RegWr = 1'b0; ticks(DEPTH); tick();
    Run = 1'b0; RegWr = 1'b1; Rw = 9; busW = 32'h99; tick();
    Run = 1'b1; RegWr = 1'b0; set_ra(9, 9); tick(); tick();

    // Reset in the middle of a clear restarts it
    Rst = 1'b1; tick(); Rst = 1'b0; ticks(10);
    Rst = 1'b1; tick(); Rst = 1'b0; ticks(DEPTH + 2);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      Rst   = ($urandom_range(0, 299) == 0);
      Clr   = ($urandom_range(0, 199) == 0);
      Stall = ($urandom_range(0, 4) == 0);
      Run   = ($urandom_range(0, 9) != 0);
      RegWr = ($urandom_range(0, 1) == 1);
      Rw    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      busW  = $urandom;
      set_ra(($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)));
      tick();
    end
    idle();

    @(negedge Clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
